// File: rtl/cmb_ctrl_pkg.sv
// cmb_ctrl_pkg: shared CMB timebase constants, channel state encoding and divider helper
package cmb_ctrl_pkg;
  localparam int CLK_HZ_DEF = 100_000_000;
  localparam int TICK_HZ_DEF = 1000;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_e;
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible index at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] ptr_o
);
  // scan from farthest to nearest so the nearest eligible index wins
  always_comb begin
    grant_o = '0;
    ptr_o = ptr_i;
    for (int k = N - 1; k >= 0; k--)
      if (elig_i[PW'((int'(ptr_i) + k) % N)]) begin
        grant_o = '0;
        grant_o[PW'((int'(ptr_i) + k) % N)] = 1'b1;
        ptr_o = PW'((int'(ptr_i) + k + 1) % N);
      end
  end
endmodule

// File: rtl/timer_sched.sv
// timer_sched: shared prescaled tick plus N_CH one-shot countdown timers loaded via round-robin; SQUARE_OUT_EN adds clk_1Hz
module timer_sched
  import cmb_ctrl_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int TICK_HZ = TICK_HZ_DEF,
  parameter int N_CH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  fpga_clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*CNT_W-1:0] load_val,
  output logic [N_CH-1:0]       gnt,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done,
`ifdef SQUARE_OUT_EN
  output logic                  clk_1Hz,
`endif
  output logic                  tick
);
  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PCW = $clog2(DIV);
  localparam int PW = $clog2(N_CH);
  logic [PCW-1:0] pcnt_q;
  logic tick_q;
  logic [N_CH-1:0] gnt_q, grant;
  logic [PW-1:0] ptr_q, ptr_d;
  // prescaler: frozen by en; a pending tick is held while frozen and released when en returns
  always_ff @(posedge fpga_clk)
    if (rst) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else if (en) begin
      pcnt_q <= (pcnt_q == PCW'(DIV - 1)) ? '0 : pcnt_q + 1'b1;
      tick_q <= pcnt_q == PCW'(DIV - 1);
    end
  assign tick = tick_q & en;
  rr_arbiter #(.N(N_CH), .PW(PW)) u_arb (
    .elig_i (req & ~busy),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .ptr_o  (ptr_d)
  );
  // registered grant pulse; pointer only moves past a granted channel
  always_ff @(posedge fpga_clk)
    if (rst) begin
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= grant;
      if (|grant) ptr_q <= ptr_d;
    end
  assign gnt = gnt_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_e st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, ld;
    logic done_q, done_d;
    assign ld = load_val[i*CNT_W +: CNT_W];
    // countdown on tick; a grant on this edge loads fresh and ignores the coincident tick
    always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      done_d = 1'b0;
      if (st_q == RUN && tick) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          st_d = IDLE;
          done_d = 1'b1;
        end
      end
      if (grant[i]) begin
        st_d = (ld != '0) ? RUN : st_d;
        cnt_d = (ld != '0) ? ld : cnt_d;
        done_d = ld == '0;
      end
    end
    // channel state register
    always_ff @(posedge fpga_clk)
      if (rst) begin
        st_q <= IDLE;
        cnt_q <= '0;
        done_q <= 1'b0;
      end else begin
        st_q <= st_d;
        cnt_q <= cnt_d;
        done_q <= done_d;
      end
    assign busy[i] = st_q == RUN;
    assign done[i] = done_q;
  end
`ifdef SQUARE_OUT_EN
  localparam int HALF = TICK_HZ / 2;
  localparam int HW = $clog2(HALF + 1);
  logic [HW-1:0] hcnt_q;
  logic sq_q;
  // half-second tick counter toggling the 1 Hz square wave
  always_ff @(posedge fpga_clk)
    if (rst) begin
      hcnt_q <= '0;
      sq_q <= 1'b0;
    end else if (tick) begin
      hcnt_q <= (hcnt_q == HW'(HALF - 1)) ? '0 : hcnt_q + 1'b1;
      if (hcnt_q == HW'(HALF - 1)) sq_q <= ~sq_q;
    end
  assign clk_1Hz = sq_q;
`endif
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed scenarios plus randomized traffic checked against a cycle-level behavioural model
module tb_timer_sched;
  localparam int CLK_HZ = 1000, TICK_HZ = 100, N = 4, W = 16, DIV = CLK_HZ / TICK_HZ;
  logic fpga_clk = 1'b0, rst = 1'b1, en = 1'b0, tick;
  logic [N-1:0] req = '0, gnt, busy, done;
  logic [N*W-1:0] load_val = '0;
  int n_cmp = 0, n_bad = 0;
  int m_en_cnt = 0, m_ptr = 0;
  int m_rem [N] = '{default: 0};
  logic [N-1:0] m_gnt = '0, m_done = '0;
  int lat_ref, lat_frz;

  always #5 fpga_clk = ~fpga_clk;

  timer_sched #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_CH(N), .CNT_W(W)) dut (
    .fpga_clk(fpga_clk), .rst(rst), .en(en), .req(req), .load_val(load_val),
    .gnt(gnt), .busy(busy), .done(done), .tick(tick)
  );

  function automatic logic exp_tick();
    return en && m_en_cnt > 0 && (m_en_cnt % DIV) == 0;
  endfunction

  function automatic logic [N-1:0] m_busy();
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = m_rem[i] > 0;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] pre;
    logic tk;
    int w;
    if (rst) begin
      m_en_cnt = 0; m_ptr = 0; m_gnt = '0; m_done = '0;
      for (int i = 0; i < N; i++) m_rem[i] = 0;
      return;
    end
    tk = exp_tick();
    pre = m_busy();
    m_gnt = '0; m_done = '0;
    for (int i = 0; i < N; i++)
      if (m_rem[i] > 0 && tk) begin
        m_rem[i]--;
        if (m_rem[i] == 0) m_done[i] = 1'b1;
      end
    for (int k = 0; k < N; k++) begin
      w = (m_ptr + k) % N;
      if (req[w] && !pre[w]) begin
        m_gnt[w] = 1'b1;
        m_ptr = (w + 1) % N;
        m_rem[w] = int'(load_val[w*W +: W]);
        if (m_rem[w] == 0) m_done[w] = 1'b1;
        break;
      end
    end
    if (en) m_en_cnt++;
  endtask

  task automatic step();
    model_edge();
    @(posedge fpga_clk);
    #1;
    chk("gnt", gnt, m_gnt);
    chk("busy", busy, m_busy());
    chk("done", done, m_done);
    chk("tick", tick, exp_tick());
    req = req & ~m_gnt;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_load(input int ch, input int v);
    load_val[ch*W +: W] = W'(v);
  endtask

  task automatic wait_idle(input int lim);
    int c = 0;
    while ((m_busy() != '0 || req != '0) && c < lim) begin
      step();
      c++;
    end
    chk("idle_bound", c < lim, 1);
  endtask

  task automatic run_ch1(input int gap, output int lat);
    int c = 0;
    while (!exp_tick() && c < 3 * DIV) begin
      step();
      c++;
    end
    set_load(1, 4);
    req[1] = 1'b1;
    step();
    chk("s5_gnt", gnt, 4'b0010);
    lat = 0;
    do begin
      step();
      lat++;
      if (gap > 0 && lat == 12) en = 1'b0;
      if (gap > 0 && lat == 12 + gap) en = 1'b1;
    end while (done[1] !== 1'b1 && lat < 200);
  endtask

  initial begin
    // 1: reset then free-running timebase
    rst = 1'b1; en = 1'b1;
    steps(3);
    rst = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c % DIV == 0) chk("s1_tick", tick, 1);
    end
    // 2: single load of 3 ticks
    set_load(0, 3); req[0] = 1'b1;
    step();
    chk("s2_gnt", gnt, 4'b0001);
    chk("s2_busy", busy[0], 1);
    wait_idle(60);
    // 3: all channels from ptr 0, then wrapped re-request
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_load(i, 5);
    req = 4'b1111;
    step(); chk("s3_g0", gnt, 4'b0001);
    step(); chk("s3_g1", gnt, 4'b0010);
    step(); chk("s3_g2", gnt, 4'b0100);
    step(); chk("s3_g3", gnt, 4'b1000);
    wait_idle(100);
    req = 4'b0011;
    step(); chk("s3_wrap", gnt, 4'b0001);
    wait_idle(100);
    // 4: zero load completes immediately
    set_load(2, 0); req[2] = 1'b1;
    step();
    chk("s4_gnt", gnt, 4'b0100);
    chk("s4_done", done, 4'b0100);
    chk("s4_busy", busy, 4'b0000);
    steps(3);
    // 5: freeze shifts expiry by exactly the frozen cycles
    run_ch1(0, lat_ref);
    chk("s5_ref_lat", lat_ref, 4 * DIV);
    wait_idle(20);
    run_ch1(25, lat_frz);
    chk("s5_frz_lat", lat_frz, 4 * DIV + 25);
    wait_idle(20);
    // 6: reset aborts busy channels silently and restarts the timebase
    for (int i = 0; i < N; i++) set_load(i, 50);
    req = 4'b1111;
    steps(6);
    chk("s6_busy_pre", busy, 4'b1111);
    rst = 1'b1; step(); rst = 1'b0;
    chk("s6_busy", busy, 4'b0000);
    chk("s6_done", done, 4'b0000);
    for (int c = 1; c <= DIV; c++) begin
      step();
      if (c == DIV) chk("s6_tick", tick, 1);
    end
    // randomized traffic with occasional freezes
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 5) == 0) begin
          set_load(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6));
          req[i] = 1'b1;
        end
      en = $urandom_range(0, 9) != 0;
      step();
    end
    en = 1'b1;
    req = '0;
    wait_idle(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
